sequenciador_sensores_param: RTL and testbench

- Parametrised control unit for the sensor-measure / serial-report / reply-receive sequence.
- Owns its own counters internally: wait timer, byte index, sensor index, reception index and reception timeout. No external counter inputs.
- Adds three features: continuous (auto-repeat) mode, reception timeout with an error exit, and an abort input.
- Sits between the start/control logic, the sensor interface, the serial TX and the serial RX.

---
 rtl/sequenciador_sensores_param.sv | 170 +++++++++++++++++
 tb/tb_sequenciador_sensores_param.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_sensores_param.sv
// Sequencer for the sensor measure / serial report / reply receive cycle.
// Adds continuous mode, a reception timeout with error exit, and abort.
module sequenciador_sensores_param #(
  parameter int N_SENSORES     = 3,
  parameter int N_BYTES        = 4,
  parameter int N_RX           = 3,
  parameter int CICLOS_ESPERA  = 50000000,
  parameter int CICLOS_TIMEOUT = 100000000,
  localparam int SW = (N_SENSORES > 1) ? $clog2(N_SENSORES) : 1,
  localparam int BW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1,
  localparam int RW = (N_RX > 1) ? $clog2(N_RX) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          jogar,
  input  logic          parar,
  input  logic          modo_continuo,
  input  logic          pronto_serial,
  input  logic          pronto_recepcao,
  output logic          medir,
  output logic          partida_tx,
  output logic [SW-1:0] sel_sensor,
  output logic [BW-1:0] sel_byte,
  output logic [RW-1:0] idx_rx,
  output logic          pronto,
  output logic          erro_timeout,
  output logic [3:0]    db_estado
);

  localparam int TW = (CICLOS_ESPERA > 1) ? $clog2(CICLOS_ESPERA) : 1;
  localparam int OW = (CICLOS_TIMEOUT > 1) ? $clog2(CICLOS_TIMEOUT) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(N_SENSORES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N_BYTES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(N_RX - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CICLOS_ESPERA - 1);
  localparam logic [OW-1:0] O_LAST = OW'(CICLOS_TIMEOUT - 1);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    MEDIR     = 4'd1,
    ESPERA    = 4'd2,
    ENVIA     = 4'd3,
    ESPERA_TX = 4'd4,
    PROX_TX   = 4'd5,
    ESPERA_RX = 4'd6,
    PROX_RX   = 4'd7,
    FINAL     = 4'd8,
    ERRO      = 4'd9
  } estado_t;

  estado_t       estado_q;
  logic [TW-1:0] tim_q;
  logic [OW-1:0] tmo_q;
  logic [SW-1:0] sens_q;
  logic [BW-1:0] byte_q;
  logic [RW-1:0] rx_q;
  logic          erro_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      tim_q    <= '0;
      tmo_q    <= '0;
      sens_q   <= '0;
      byte_q   <= '0;
      rx_q     <= '0;
      erro_q   <= 1'b0;
    end else if (parar && estado_q != INICIAL) begin
      // abort keeps the error flag so the host can still read it
      estado_q <= INICIAL;
      tim_q    <= '0;
      tmo_q    <= '0;
      sens_q   <= '0;
      byte_q   <= '0;
      rx_q     <= '0;
    end else begin
      case (estado_q)
        INICIAL: begin
          tim_q  <= '0;
          tmo_q  <= '0;
          sens_q <= '0;
          byte_q <= '0;
          rx_q   <= '0;
          if (jogar) estado_q <= MEDIR;
        end
        MEDIR: begin
          erro_q   <= 1'b0;
          estado_q <= ESPERA;
        end
        ESPERA: begin
          if (tim_q == T_LAST) begin
            tim_q    <= '0;
            estado_q <= ENVIA;
          end else begin
            tim_q <= tim_q + TW'(1);
          end
        end
        ENVIA: estado_q <= ESPERA_TX;
        ESPERA_TX: begin
          if (pronto_serial) estado_q <= PROX_TX;
        end
        PROX_TX: begin
          if (byte_q != B_LAST) begin
            byte_q   <= byte_q + BW'(1);
            estado_q <= ENVIA;
          end else begin
            byte_q <= '0;
            if (sens_q != S_LAST) begin
              sens_q   <= sens_q + SW'(1);
              estado_q <= ENVIA;
            end else begin
              sens_q   <= '0;
              tmo_q    <= '0;
              estado_q <= ESPERA_RX;
            end
          end
        end
        ESPERA_RX: begin
          // a reception on the terminal cycle beats the timeout
          if (pronto_recepcao) begin
            estado_q <= PROX_RX;
          end else if (tmo_q == O_LAST) begin
            estado_q <= ERRO;
          end else begin
            tmo_q <= tmo_q + OW'(1);
          end
        end
        PROX_RX: begin
          tmo_q <= '0;
          if (rx_q != R_LAST) begin
            rx_q     <= rx_q + RW'(1);
            estado_q <= ESPERA_RX;
          end else begin
            rx_q     <= '0;
            estado_q <= FINAL;
          end
        end
        FINAL: estado_q <= modo_continuo ? MEDIR : INICIAL;
        ERRO: begin
          erro_q   <= 1'b1;
          tim_q    <= '0;
          tmo_q    <= '0;
          sens_q   <= '0;
          byte_q   <= '0;
          rx_q     <= '0;
          estado_q <= INICIAL;
        end
        default: begin
          tim_q    <= '0;
          tmo_q    <= '0;
          sens_q   <= '0;
          byte_q   <= '0;
          rx_q     <= '0;
          estado_q <= INICIAL;
        end
      endcase
    end
  end

  assign medir        = (estado_q == MEDIR);
  assign partida_tx   = (estado_q == ENVIA);
  assign pronto       = (estado_q == FINAL);
  assign sel_sensor   = sens_q;
  assign sel_byte     = byte_q;
  assign idx_rx       = rx_q;
  assign erro_timeout = erro_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_sequenciador_sensores_param.sv
// Directed bench for sequenciador_sensores_param with small parameters.
// Auto responders emulate the serial TX/RX; tasks check each scenario.
module tb_sequenciador_sensores_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic       parar = 1'b0;
  logic       modo_continuo = 1'b0;
  logic       pronto_serial = 1'b0;
  logic       pronto_recepcao = 1'b0;
  logic       medir, partida_tx, pronto, erro_timeout;
  logic [0:0] sel_sensor, sel_byte, idx_rx;
  logic [3:0] db_estado;

  sequenciador_sensores_param #(
    .N_SENSORES(2), .N_BYTES(2), .N_RX(2),
    .CICLOS_ESPERA(4), .CICLOS_TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .parar(parar),
    .modo_continuo(modo_continuo), .pronto_serial(pronto_serial),
    .pronto_recepcao(pronto_recepcao), .medir(medir),
    .partida_tx(partida_tx), .sel_sensor(sel_sensor),
    .sel_byte(sel_byte), .idx_rx(idx_rx), .pronto(pronto),
    .erro_timeout(erro_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  bit tx_auto = 1'b1;
  bit tx_stuck = 1'b0;
  bit rx_en = 1'b1;
  int rx_at = 5;

  int cyc = 0, tx_cnt = 0, rx_cnt = 0;
  int n_tx = 0, n_medir = 0, n_pronto = 0;
  int n_erro = 0, n_idle = 0, n_prox = 0;
  int last_rx_cyc = 0, pronto_cyc = 0;
  logic [1:0] log_q [0:63];

  // serial responders and event monitor
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (partida_tx) begin
      log_q[n_tx % 64] = {sel_sensor, sel_byte};
      n_tx = n_tx + 1;
      tx_cnt = 3;
    end else if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
    end
    pronto_serial = tx_stuck || (tx_auto && tx_cnt == 1);
    if (db_estado == 4'd6) rx_cnt = rx_cnt + 1;
    else rx_cnt = 0;
    pronto_recepcao = rx_en && (rx_cnt == rx_at);
    if (pronto_recepcao) last_rx_cyc = cyc;
    if (pronto) begin
      n_pronto = n_pronto + 1;
      pronto_cyc = cyc;
    end
    if (medir) n_medir = n_medir + 1;
    if (db_estado == 4'd9) n_erro = n_erro + 1;
    if (db_estado == 4'd0) n_idle = n_idle + 1;
    if (db_estado == 4'd5) n_prox = n_prox + 1;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int lim,
                            output bit ok);
    int n;
    n = 0;
    while (db_estado !== s && n < lim) begin
      tick();
      n++;
    end
    ok = (db_estado === s);
  endtask

  task automatic pulse_jogar();
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", db_estado);
    end
    checks++;
    if ({medir, partida_tx, sel_sensor, sel_byte, idx_rx, pronto,
         erro_timeout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {medir, partida_tx, sel_sensor, sel_byte, idx_rx, pronto,
                erro_timeout});
    end
  endtask

  task automatic test_nominal();
    int b_tx, b_md, b_pr, k;
    bit ok;
    logic [7:0] seq;
    b_tx = n_tx; b_md = n_medir; b_pr = n_pronto;
    rx_en = 1'b1; rx_at = 5;
    pulse_jogar();
    checks++;
    if ({db_estado, medir} !== {4'd1, 1'b1}) begin
      errors++;
      $display("FAIL nom_medir: got st=%0d medir=%0d expected st=1 medir=1",
               db_estado, medir);
    end
    tick();
    k = 0;
    while (db_estado === 4'd2 && k < 20) begin
      k++;
      tick();
    end
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL nom_espera_len: got %0d expected 4", k);
    end
    checks++;
    if (partida_tx !== 1'b1) begin
      errors++;
      $display("FAIL nom_envia: got partida=%0d expected 1", partida_tx);
    end
    wait_state(4'd8, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nom_final_timeout: got st=%0d expected 8", db_estado);
    end
    checks++;
    if (pronto_cyc - last_rx_cyc !== 2) begin
      errors++;
      $display("FAIL nom_pronto_lat: got %0d expected 2",
               pronto_cyc - last_rx_cyc);
    end
    tick();
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("FAIL nom_return: got %0d expected 0", db_estado);
    end
    checks++;
    if ({n_tx - b_tx, n_medir - b_md, n_pronto - b_pr} !== {32'd4, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL nom_counts: got tx=%0d medir=%0d pronto=%0d expected 4 1 1",
               n_tx - b_tx, n_medir - b_md, n_pronto - b_pr);
    end
    seq = {log_q[b_tx % 64], log_q[(b_tx + 1) % 64],
           log_q[(b_tx + 2) % 64], log_q[(b_tx + 3) % 64]};
    checks++;
    if (seq !== 8'b00_01_10_11) begin
      errors++;
      $display("FAIL nom_order: got %b expected 00011011", seq);
    end
  endtask

  task automatic test_timeout();
    int k;
    bit ok;
    rx_en = 1'b0;
    pulse_jogar();
    wait_state(4'd6, 200, ok);
    k = 0;
    while (db_estado === 4'd6 && k < 20) begin
      k++;
      tick();
    end
    checks++;
    if ({ok, db_estado} !== {1'b1, 4'd9} || k !== 8) begin
      errors++;
      $display("FAIL tmo_erro: got st=%0d cycles=%0d expected st=9 cycles=8",
               db_estado, k);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({db_estado, erro_timeout, idx_rx} !== {4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tmo_sticky: got st=%0d erro=%0d idx=%0d expected 0 1 0",
               db_estado, erro_timeout, idx_rx);
    end
    rx_en = 1'b1;
    pulse_jogar();
    tick();
    checks++;
    if ({db_estado, erro_timeout} !== {4'd2, 1'b0}) begin
      errors++;
      $display("FAIL tmo_clear: got st=%0d erro=%0d expected 2 0",
               db_estado, erro_timeout);
    end
    parar = 1'b1;
    tick();
    parar = 1'b0;
  endtask

  task automatic test_simultaneous();
    int b_er, b_pr;
    bit ok;
    b_er = n_erro; b_pr = n_pronto;
    rx_en = 1'b1; rx_at = 8;
    pulse_jogar();
    wait_state(4'd8, 400, ok);
    tick();
    checks++;
    if (!ok || n_erro - b_er !== 0 || n_pronto - b_pr !== 1) begin
      errors++;
      $display("FAIL sim_rx_wins: got erro=%0d pronto=%0d expected 0 1",
               n_erro - b_er, n_pronto - b_pr);
    end
    checks++;
    if ({db_estado, erro_timeout} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL sim_end: got st=%0d erro=%0d expected 0 0",
               db_estado, erro_timeout);
    end
    rx_at = 5;
  endtask

  task automatic test_continuous();
    int b_tx, b_md, b_pr, b_id, n;
    b_tx = n_tx; b_md = n_medir; b_pr = n_pronto;
    modo_continuo = 1'b1;
    pulse_jogar();
    b_id = n_idle;
    n = 0;
    while (n_pronto - b_pr < 3 && n < 1000) begin
      tick();
      n++;
    end
    modo_continuo = 1'b0;
    checks++;
    if (n_idle - b_id !== 0) begin
      errors++;
      $display("FAIL cont_no_idle: got %0d expected 0", n_idle - b_id);
    end
    tick();
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("FAIL cont_stop: got %0d expected 0", db_estado);
    end
    checks++;
    if ({n_tx - b_tx, n_medir - b_md, n_pronto - b_pr} !== {32'd12, 32'd3, 32'd3}) begin
      errors++;
      $display("FAIL cont_counts: got tx=%0d medir=%0d pronto=%0d expected 12 3 3",
               n_tx - b_tx, n_medir - b_md, n_pronto - b_pr);
    end
  endtask

  task automatic test_abort();
    int n, b_tx;
    rx_at = 5;
    pulse_jogar();
    n = 0;
    while (!(db_estado === 4'd4 && sel_byte === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    parar = 1'b1;
    tick();
    parar = 1'b0;
    checks++;
    if ({db_estado, sel_sensor, sel_byte, idx_rx} !== 7'd0 || n >= 200) begin
      errors++;
      $display("FAIL abort_idle: got st=%0d s=%0d b=%0d r=%0d expected 0",
               db_estado, sel_sensor, sel_byte, idx_rx);
    end
    b_tx = n_tx;
    pulse_jogar();
    n = 0;
    while (n_tx == b_tx && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n_tx == b_tx || log_q[b_tx % 64] !== 2'b00) begin
      errors++;
      $display("FAIL abort_restart: got first=%b expected 00",
               log_q[b_tx % 64]);
    end
    n = 0;
    while (!(db_estado === 4'd6 && idx_rx === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({db_estado, medir, partida_tx, sel_sensor, sel_byte, idx_rx,
         pronto, erro_timeout} !== 11'd0 || n >= 200) begin
      errors++;
      $display("FAIL reset_mid_rx: got st=%0d idx=%0d expected all 0",
               db_estado, idx_rx);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int b_tx, b_pv, b_pr, n;
    logic [7:0] seq;
    tx_stuck = 1'b1;
    reset = 1'b1;
    jogar = 1'b1;
    tick();
    tick();
    b_tx = n_tx; b_pv = n_prox; b_pr = n_pronto;
    reset = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'd1) begin
      errors++;
      $display("FAIL held_jogar: got %0d expected 1", db_estado);
    end
    n = 0;
    while (n_pronto == b_pr && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n_tx - b_tx !== 4 || n_prox - b_pv !== 4) begin
      errors++;
      $display("FAIL stuck_tx_count: got tx=%0d prox=%0d expected 4 4",
               n_tx - b_tx, n_prox - b_pv);
    end
    seq = {log_q[b_tx % 64], log_q[(b_tx + 1) % 64],
           log_q[(b_tx + 2) % 64], log_q[(b_tx + 3) % 64]};
    checks++;
    if (seq !== 8'b00_01_10_11) begin
      errors++;
      $display("FAIL stuck_tx_order: got %b expected 00011011", seq);
    end
    tick();
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("FAIL held_final: got %0d expected 0", db_estado);
    end
    tick();
    checks++;
    if (db_estado !== 4'd1) begin
      errors++;
      $display("FAIL held_rearm: got %0d expected 1", db_estado);
    end
    jogar = 1'b0;
    parar = 1'b1;
    tick();
    parar = 1'b0;
    tx_stuck = 1'b0;
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("FAIL parar_medir: got %0d expected 0", db_estado);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_simultaneous();
    test_continuous();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
